out_monitor: RTL
================

OUT_MONITOR -- requirements
Module: out_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 16, meaning timestamp counter width.
REQ-003 SHALL have parameter STABLE_CYC, default 64, meaning the number of unchanged sampled cycles that declares the output settled.
REQ-004 SHALL have port clk_pri, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port out_in, input, 10 bits: core OUT bus under observation.
REQ-007 SHALL have port en, input, 1 bit: monitor enable.
REQ-008 SHALL have port rd_ready, input, 1 bit: consumer ready.
REQ-009 SHALL have port rd_valid, output, 1 bit: FIFO head valid.
REQ-010 SHALL have port rd_data, output, TS_W+10 bits: {timestamp, value} at FIFO head.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-013 SHALL have port settled, output, 1 bit: high in the SETTLED state.

Function
REQ-014 SHALL register out_in into in_q every cycle; all comparisons use in_q, never raw out_in.
REQ-015 SHALL run a free-running ts counter: 0 after reset, +1 per cycle, saturating at all-ones.
REQ-016 SHALL implement states IDLE, TRACK, SETTLED.
REQ-017 IDLE: on the first cycle with en=1, SHALL push {ts, in_q} as the baseline, load last_val=in_q, clear stable_cnt, and go to TRACK.
REQ-018 TRACK/SETTLED: in_q != last_val SHALL push {ts, in_q}, update last_val, clear stable_cnt, and go or stay in TRACK.
REQ-019 TRACK: each unchanged cycle SHALL increment stable_cnt; when stable_cnt reaches STABLE_CYC-1 and in_q is unchanged, SHALL enter SETTLED.
REQ-020 SETTLED SHALL hold with no pushes while in_q is unchanged.
REQ-021 en=0 in any state SHALL return to IDLE at the next edge with no push; FIFO contents, overflow and ts are retained.
REQ-022 Latency: a new out_in value present before edge k SHALL be in in_q after edge k, pushed at edge k+1, and visible as rd_valid=1 with that entry at head after edge k+1 when the FIFO was empty.
REQ-023 rd_valid SHALL equal (count != 0); rd_data SHALL be the oldest entry and held stable while rd_valid=1 and rd_ready=0.
REQ-024 Pop SHALL occur on the edge where rd_valid and rd_ready are both 1.
REQ-025 Simultaneous push and pop SHALL both take effect, leaving count unchanged, including when full.
REQ-026 Push when full without a same-cycle pop SHALL drop the new entry, set overflow, and still update last_val.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-028 While reset=1 at an edge, SHALL clear state to IDLE and clear ts, stable_cnt, pointers, count, overflow, last_val and in_q to 0.
REQ-029 While reset=1, outputs SHALL be rd_valid=0, count=0, overflow=0, settled=0; rd_data is don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents in one cycle, with no pop completing on that edge.
REQ-031 overflow SHALL clear only by reset.

Verification
REQ-032 Reset 6 cycles, then en=1, out_in=0 held -> one entry {ts, 0}, rd_valid 2 cycles after en; settled=1 after STABLE_CYC unchanged cycles.
REQ-033 rd_ready=1, out_in steps 0->5->12 with 3 cycles per value -> entries with values 0, 5, 12 whose timestamps differ by 3; each entry appears 2 cycles after its input change.
REQ-034 rd_ready=0, 10 distinct values, one per cycle, DEPTH=8 -> count=8, overflow=1, head holds the first value, last two values dropped.
REQ-035 Full FIFO, rd_ready=1 and a new value in the same cycle -> count stays 8, overflow stays 0, new entry at the tail.
REQ-036 In SETTLED, out_in changes 12->13 -> settled=0 the cycle after the push, new entry with value 13, and STABLE_CYC more stable cycles required to resettle.
REQ-037 With 3 entries queued, en=0 then reset=1 -> after en=0, state is IDLE and count=3; after reset, count=0, rd_valid=0, ts=0.

Source files
------------

// File: rtl/out_monitor.sv
// Watches the 10-bit core OUT bus and queues {timestamp, value} on every change.
// A small FIFO buffers the entries for the consumer; a settle detector reports a quiet bus.
module out_monitor #(
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16,
  parameter int STABLE_CYC = 64
) (
  input  logic                     clk_pri,
  input  logic                     reset,
  input  logic [9:0]               out_in,
  input  logic                     en,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W+9:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     settled
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STABLE_CYC) + 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SC_MAX   = SW'(STABLE_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_SETTLED = 2'd2;

  logic [1:0]       r_state;
  logic [9:0]       r_in_q;
  logic [9:0]       r_last;
  logic [TS_W-1:0]  r_ts;
  logic [SW-1:0]    r_stable;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic [TS_W+9:0]  r_mem [DEPTH];

  logic w_changed, w_push, w_full, w_pop, w_wr;

  always_comb begin
    w_changed = (r_in_q != r_last);
    // IDLE always captures a baseline on enable; otherwise only real changes are pushed
    w_push    = en && ((r_state == S_IDLE) || w_changed);
    w_full    = (r_count == FULL_CNT);
    w_pop     = (r_count != '0) && rd_ready;
    w_wr      = w_push && (!w_full || w_pop);
  end

  always_ff @(posedge clk_pri) begin
    if (!reset && w_wr) r_mem[r_wptr] <= {r_ts, r_in_q};
  end

  always_ff @(posedge clk_pri) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_in_q   <= '0;
      r_last   <= '0;
      r_ts     <= '0;
      r_stable <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_in_q <= out_in;
      if (r_ts != '1) r_ts <= r_ts + 1'b1;

      if (!en) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE || w_changed) begin
        r_last   <= r_in_q;
        r_stable <= '0;
        r_state  <= S_TRACK;
      end else if (r_state == S_TRACK) begin
        if (r_stable == SC_MAX) r_state  <= S_SETTLED;
        else                    r_stable <= r_stable + 1'b1;
      end

      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign rd_valid = (r_count != '0);
  assign rd_data  = r_mem[r_rptr];
  assign count    = r_count;
  assign overflow = r_ovf;
  assign settled  = (r_state == S_SETTLED);

endmodule
